// File: rtl/voice_allocator_if.sv
// Event channel into the voice allocator plus its assignment strobe bus back out.
// Latency: n/a (wires only); ev_valid/ev_ready is a plain valid-ready handshake.
// Backpressure: source holds ev_* with ev_valid high until it sees ev_ready high at a clock edge.
// Ports:
//   ev_valid, ev_type, ev_note, ev_vel  : event offered by the sequencer
//   ev_ready                            : allocator can take an event this cycle
//   assign_stb/adr/note/vel/gate, steal : per-voice assignment results to the synth engine
interface voice_allocator_if #(
    parameter int V_WIDTH = 3
);
    logic               ev_valid;
    logic               ev_ready;
    logic [1:0]         ev_type;
    logic [6:0]         ev_note;
    logic [6:0]         ev_vel;

    logic               assign_stb;
    logic [V_WIDTH-1:0] assign_adr;
    logic [7:0]         assign_note;
    logic [6:0]         assign_vel;
    logic               assign_gate;
    logic               steal;

    // Sequencer / engine side.
    modport master (
        output ev_valid, ev_type, ev_note, ev_vel,
        input  ev_ready,
        input  assign_stb, assign_adr, assign_note, assign_vel, assign_gate, steal
    );

    // Allocator side.
    modport slave (
        input  ev_valid, ev_type, ev_note, ev_vel,
        output ev_ready,
        output assign_stb, assign_adr, assign_note, assign_vel, assign_gate, steal
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto VOICES synth voices.
// Latency: note events strobe VOICES+1 cycles after transfer, ready again at VOICES+2; other types ready at 2.
// Backpressure: ev_ready high only in IDLE (and never during reset); one event in flight at a time.
// Ports:
//   CLOCK_50, reset_reg : clock, synchronous active-high reset
//   ev_if (slave)       : event handshake in, assignment strobe bus out
//   voice_free          : per-voice "envelope finished" flag from the engine
//   key_on              : per-voice gate to the engine
//   active_keys         : number of voices currently gated on
module voice_allocator #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic                CLOCK_50,
    input  logic                reset_reg,
    voice_allocator_if.slave    ev_if,
    input  logic [VOICES-1:0]   voice_free,
    output logic [VOICES-1:0]   key_on,
    output logic [V_WIDTH:0]    active_keys
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] typ;
        logic [6:0] note;
        logic [6:0] vel;
    } ev_t;

    // Best candidate found so far for one selection rule.
    typedef struct packed {
        logic               found;
        logic [V_WIDTH-1:0] idx;
        logic [7:0]         age;
    } cand_t;

    localparam logic [1:0]         EV_ON    = 2'b00;
    localparam logic [1:0]         EV_OFF   = 2'b01;
    localparam logic [1:0]         EV_ALL   = 2'b10;
    localparam logic [7:0]         NO_KEY   = 8'hff;
    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

    state_t             state;
    state_t             state_nxt;
    ev_t                ev_q;
    logic [V_WIDTH-1:0] scan_idx;
    logic [7:0]         key_val [VOICES];
    logic [7:0]         age     [VOICES];

    // ret: held voice already playing this note; free: idle and engine-free;
    // off: idle, oldest; on: held, oldest (steal victim).
    cand_t ret_q,  free_q,  off_q,  on_q;
    cand_t ret_c,  free_c,  off_c,  on_c;
    cand_t here;

    logic               take;
    logic               last_scan;
    logic               hit;
    logic [V_WIDTH-1:0] tgt;
    logic               inc;
    logic               stl;

    logic               stb_q;
    logic               steal_q;
    logic               gate_q;
    logic               inc_q;
    logic [V_WIDTH-1:0] adr_q;
    logic [7:0]         note_out_q;
    logic [6:0]         vel_out_q;

    assign ev_if.ev_ready    = (state == IDLE) && !reset_reg;
    assign ev_if.assign_stb  = stb_q;
    assign ev_if.steal       = steal_q;
    assign ev_if.assign_adr  = adr_q;
    assign ev_if.assign_note = note_out_q;
    assign ev_if.assign_vel  = vel_out_q;
    assign ev_if.assign_gate = gate_q;

    assign take      = ev_if.ev_valid && ev_if.ev_ready;
    assign last_scan = (state == SCAN) && (scan_idx == LAST_IDX);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge CLOCK_50) begin
        if (reset_reg) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // ev_type[1] set: all-notes-off or reserved, no voice search needed.
                if (take) begin
                    state_nxt = ev_if.ev_type[1] ? ISSUE : SCAN;
                end
            end
            SCAN: begin
                if (last_scan) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------- per-cycle candidate update
    // Fold the voice visited this cycle into the running bests. Ties keep
    // the earlier (lower) index because only a strictly greater age wins.
    always_comb begin
        here.found = 1'b1;
        here.idx   = scan_idx;
        here.age   = age[scan_idx];
        ret_c      = ret_q;
        free_c     = free_q;
        off_c      = off_q;
        on_c       = on_q;
        if (key_on[scan_idx]) begin
            if (!ret_q.found && (key_val[scan_idx] == {1'b0, ev_q.note})) begin
                ret_c = here;
            end
            if (!on_q.found || (age[scan_idx] > on_q.age)) begin
                on_c = here;
            end
        end else begin
            if (!free_q.found && voice_free[scan_idx]) begin
                free_c = here;
            end
            if (!off_q.found || (age[scan_idx] > off_q.age)) begin
                off_c = here;
            end
        end
    end

    // Final choice, only meaningful on the last SCAN cycle.
    always_comb begin
        hit = 1'b0;
        tgt = '0;
        inc = 1'b0;
        stl = 1'b0;
        if (ev_q.typ == EV_ON) begin
            hit = 1'b1;
            if (ret_c.found) begin
                tgt = ret_c.idx;
            end else if (free_c.found) begin
                tgt = free_c.idx;
                inc = 1'b1;
            end else if (off_c.found) begin
                tgt = off_c.idx;
                inc = 1'b1;
            end else begin
                // Every voice is held: take the oldest one.
                tgt = on_c.idx;
                stl = 1'b1;
            end
        end else if (ev_q.typ == EV_OFF) begin
            hit = ret_c.found;
            tgt = ret_c.idx;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge CLOCK_50) begin
        if (reset_reg) begin
            ev_q        <= '0;
            scan_idx    <= '0;
            ret_q       <= '0;
            free_q      <= '0;
            off_q       <= '0;
            on_q        <= '0;
            key_on      <= '0;
            active_keys <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_val[i] <= NO_KEY;
                age[i]     <= 8'd0;
            end
            stb_q       <= 1'b0;
            steal_q     <= 1'b0;
            gate_q      <= 1'b0;
            inc_q       <= 1'b0;
            adr_q       <= '0;
            note_out_q  <= NO_KEY;
            vel_out_q   <= 7'd0;
        end else begin
            stb_q   <= 1'b0;
            steal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        // A zero-velocity note-on is a release by MIDI convention.
                        ev_q.typ  <= ((ev_if.ev_type == EV_ON) && (ev_if.ev_vel == 7'd0))
                                     ? EV_OFF : ev_if.ev_type;
                        ev_q.note <= ev_if.ev_note;
                        ev_q.vel  <= ev_if.ev_vel;
                        scan_idx  <= '0;
                        ret_q     <= '0;
                        free_q    <= '0;
                        off_q     <= '0;
                        on_q      <= '0;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + 1'b1;
                    ret_q    <= ret_c;
                    free_q   <= free_c;
                    off_q    <= off_c;
                    on_q     <= on_c;
                    // Results register on the way into ISSUE so the strobe and its
                    // qualifiers appear together and then hold until the next strobe.
                    if (last_scan && hit) begin
                        stb_q      <= 1'b1;
                        steal_q    <= stl;
                        inc_q      <= inc;
                        adr_q      <= tgt;
                        gate_q     <= (ev_q.typ == EV_ON);
                        note_out_q <= (ev_q.typ == EV_ON) ? {1'b0, ev_q.note} : NO_KEY;
                        vel_out_q  <= ev_q.vel;
                    end
                end
                ISSUE: begin
                    if (stb_q && gate_q) begin
                        key_on[adr_q]  <= 1'b1;
                        key_val[adr_q] <= note_out_q;
                        for (int i = 0; i < VOICES; i++) begin
                            if (V_WIDTH'(i) == adr_q) begin
                                age[i] <= 8'd0;
                            end else if (age[i] != 8'hff) begin
                                age[i] <= age[i] + 8'd1;
                            end
                        end
                        if (inc_q) begin
                            active_keys <= active_keys + 1'b1;
                        end
                    end else if (stb_q) begin
                        key_on[adr_q]  <= 1'b0;
                        key_val[adr_q] <= NO_KEY;
                        active_keys    <= active_keys - 1'b1;
                    end else if (ev_q.typ == EV_ALL) begin
                        key_on      <= '0;
                        active_keys <= '0;
                        for (int i = 0; i < VOICES; i++) begin
                            key_val[i] <= NO_KEY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
